intc_responder: RTL and testbench
=================================

// Module: intc_responder
// PURPOSE
//  Interrupt controller driving the CPU interrupt-request interface (cpu_pkg IntR: req/level/vector)
//  and consuming its acknowledge (IntA.ack). Latches NSRC peripheral interrupt lines, applies
//  per-source enable, priority level and edge/level mode, and presents the highest-priority
//  pending source. Sits beside the CPU in the SoC top; programmed through a simple register port.
// PARAMETERS
//  NSRC      16   number of interrupt sources, 1..32
//  VEC_BASE  64   vector number of source 0; source i presents VEC_BASE+i (8-bit wrap)
// PORTS
//  clk         in   1     clock
//  rst_n       in   1     asynchronous active-low reset
//  irq         in   NSRC  peripheral interrupt lines, active-high
//  intr_req    out  1     IntR.req: interrupt request to CPU
//  intr_level  out  4     IntR.level: priority of presented source
//  intr_vec    out  8     IntR.vector: vector of presented source
//  inta_ack    in   1     IntA.ack: single-cycle acknowledge of presented source
//  reg_sel     in   1     register access strobe, one cycle per access
//  reg_wr      in   1     1=write, 0=read
//  reg_addr    in   8     byte address, word-aligned
//  reg_wdata   in   32    write data
//  reg_rdata   out  32    read data, valid cycle after reg_sel (registered)
// BEHAVIOUR
//  Reset: one clock, async active-low reset; all state async-cleared. intr_req=0, intr_level=0,
//   intr_vec=0, reg_rdata=0, pending/enable/prio/mode all 0.
//  Registers: 0x00+4*i PRIO[i] {[8]=mode 1:edge 0:level, [3:0]=level}; 0x80 ENABLE (R/W);
//   0x84 PENDING (R, W1C; W1C ignored for level sources); 0x88 CUR {[31]=req,[11:8]=level,[7:0]=vec}.
//   Unmapped reads return 0; unmapped writes ignored. Bits >= NSRC read 0.
//  Pending: edge source sets on 0->1 of sampled irq[i]; level source pending = sampled irq[i].
//   Set beats clear: edge in same cycle as W1C or ack keeps pending=1.
//  Arbitration (comb, then registered): candidates = pending & enable & (level!=0). Winner =
//   highest level; tie -> lowest index. intr_req/level/vec registered from winner; 0 if none.
//  Latency: irq rising at edge N -> pending at N+1 -> intr_req at N+2 (NO sync build).
//  Ack: on inta_ack, source presented in that cycle is captured; if edge mode its pending
//   clears next cycle; level sources unaffected (peripheral must deassert). Output recomputes
//   the following cycle; intr_req drops for one cycle after ack even if others pending.
//  inta_ack while intr_req=0: ignored. Ack same cycle as a higher source arriving: acked source
//   is the one presented, not the new winner.
//  Reprogramming PRIO/ENABLE takes effect on next arbitration; lowering level below presented
//   value may drop intr_req next cycle (CPU tolerates request withdrawal before ack).
//  Reset mid-request: intr_req drops immediately (async), all pending lost.
// CONFIGURATION
//  INTC_IRQ_SYNC_EN defined: irq passes a 2-flop synchronizer before edge detect; latency
//   irq->intr_req becomes 4 cycles. Undefined: irq sampled by one flop (inputs assumed synchronous),
//   latency 2 cycles. Register map and ack behaviour identical in both builds.
// TESTING
//  1. Reset: PRIO[3]=0x105, ENABLE=0x8, pulse irq[3] 1 cycle -> intr_req=1, level=5, vec=67
//     at +2 cycles (+4 with INTC_IRQ_SYNC_EN); ack -> PENDING=0, intr_req=0 next cycle.
//  2. Sources 2 (lvl 7) and 5 (lvl 7) and 9 (lvl 12) pending -> vec=73; ack -> vec=66; ack -> vec=69.
//  3. Level source 1 lvl 3 held high, ack -> intr_req reasserts after 1-cycle gap; deassert irq
//     -> intr_req=0 within 2 cycles; W1C on bit1 no effect.
//  4. Edge on irq[4] coincident with W1C of bit4 and with inta_ack of src 4 -> PENDING[4] stays 1.
//  5. Pending src 0 lvl 0 or ENABLE=0 -> intr_req stays 0; set level 1 -> intr_req next cycle.
//  6. Assert rst_n low mid-request -> all outputs 0 same cycle; registers read 0 after release.

Source files
------------

// File: rtl/intc_responder.sv
// intc_responder: interrupt controller for the CPU IntR/IntA handshake.
// Samples NSRC interrupt lines and tracks a pending bit for each one, using
// edge or level mode per source. It picks the highest-priority enabled source
// (ties go to the lowest index) and presents it as a registered req/level/vector.
// Build option: define INTC_IRQ_SYNC_EN to put a 2-flop synchronizer on irq in
// front of the sampling flop. Without it, irq is assumed synchronous to clk.
module intc_responder #(
    parameter int NSRC     = 16,
    parameter int VEC_BASE = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq,
    output logic            intr_req,
    output logic [3:0]      intr_level,
    output logic [7:0]      intr_vec,
    input  logic            inta_ack,
    input  logic            reg_sel,
    input  logic            reg_wr,
    input  logic [7:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    localparam logic [7:0] ADDR_ENABLE  = 8'h80;
    localparam logic [7:0] ADDR_PENDING = 8'h84;
    localparam logic [7:0] ADDR_CUR     = 8'h88;

    logic [NSRC-1:0] r_irq_s;     // sampled irq, input to edge detect
    logic [NSRC-1:0] r_irq_prev;  // previous sample, for rising-edge detect
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_enable;
    logic [NSRC-1:0] r_mode;      // 1 = edge, 0 = level
    logic [3:0]      r_lvl [NSRC];
    logic            r_req;
    logic [3:0]      r_level;
    logic [7:0]      r_vec;
    logic [IW-1:0]   r_idx;       // index of the source currently presented
    logic [31:0]     r_rdata;

    logic            w_wr;
    logic            w_rd;
    logic            w_ack;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_rise;
    logic            w_found;
    logic [3:0]      w_win_lvl;
    logic [7:0]      w_win_vec;
    logic [IW-1:0]   w_win_idx;
    logic [31:0]     w_rd_data;
    logic            w_unused;

    assign w_wr  = reg_sel & reg_wr;
    assign w_rd  = reg_sel & ~reg_wr;
    // An ack only counts while a request is actually being presented.
    assign w_ack = inta_ack & r_req;
    // Write-data bits above the implemented sources are intentionally dropped.
    assign w_unused = &{1'b0, reg_wdata};

`ifdef INTC_IRQ_SYNC_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    // Two-stage synchronizer ahead of the sampling flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
        end
    end
`endif

    // Sample the irq lines and keep the previous sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_s    <= '0;
            r_irq_prev <= '0;
        end else begin
            // NOTE: state is always updated with <= so every flop sees pre-edge values.
`ifdef INTC_IRQ_SYNC_EN
            r_irq_s    <= r_sync2;
`else
            r_irq_s    <= irq;
`endif
            r_irq_prev <= r_irq_s;
        end
    end

    // Per-source clear requests (W1C and ack) and rising-edge detection.
    always_comb begin
        // NOTE: defaults come first so no path leaves a signal unassigned (no latch).
        w_w1c     = '0;
        w_ack_clr = '0;
        if (w_wr && reg_addr == ADDR_PENDING) begin
            w_w1c = reg_wdata[NSRC-1:0];
        end
        for (int i = 0; i < NSRC; i++) begin
            w_ack_clr[i] = w_ack && (r_idx == IW'(i));
        end
        w_rise = r_irq_s & ~r_irq_prev;
    end

    // Pending bits: an edge source is set by a rising edge, and a set in the same
    // cycle as a clear wins. A level source simply follows the sampled line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (r_mode[i]) begin
                    r_pending[i] <= w_rise[i] | (r_pending[i] & ~(w_w1c[i] | w_ack_clr[i]));
                end else begin
                    r_pending[i] <= r_irq_s[i];
                end
            end
        end
    end

    // Register writes to the PRIO and ENABLE registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the priority table is small and must come up as all zeros, so it is reset here.
            for (int i = 0; i < NSRC; i++) begin
                r_lvl[i] <= '0;
            end
            r_mode   <= '0;
            r_enable <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NSRC; i++) begin
                if (reg_addr == 8'(4 * i)) begin
                    r_mode[i] <= reg_wdata[8];
                    r_lvl[i]  <= reg_wdata[3:0];
                end
            end
            if (reg_addr == ADDR_ENABLE) begin
                r_enable <= reg_wdata[NSRC-1:0];
            end
        end
    end

    // Arbitration: the highest non-zero level among pending and enabled sources wins.
    // The strict '>' compare means a tie goes to the lowest index.
    always_comb begin
        w_found   = 1'b0;
        w_win_lvl = '0;
        w_win_vec = '0;
        w_win_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (r_pending[i] && r_enable[i] && r_lvl[i] > w_win_lvl) begin
                w_found   = 1'b1;
                w_win_lvl = r_lvl[i];
                w_win_vec = 8'(VEC_BASE + i);
                w_win_idx = IW'(i);
            end
        end
    end

    // Presented request. An ack forces one idle cycle before the next winner is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_level <= '0;
            r_vec   <= '0;
            r_idx   <= '0;
        end else if (w_ack || !w_found) begin
            r_req   <= 1'b0;
            r_level <= '0;
            r_vec   <= '0;
            r_idx   <= '0;
        end else begin
            r_req   <= 1'b1;
            r_level <= w_win_lvl;
            r_vec   <= w_win_vec;
            r_idx   <= w_win_idx;
        end
    end

    // Read-data mux. Unmapped addresses and bits at or above NSRC read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (reg_addr == 8'(4 * i)) begin
                w_rd_data[8]   = r_mode[i];
                w_rd_data[3:0] = r_lvl[i];
            end
        end
        case (reg_addr)
            ADDR_ENABLE:  w_rd_data[NSRC-1:0] = r_enable;
            ADDR_PENDING: w_rd_data[NSRC-1:0] = r_pending;
            ADDR_CUR:     w_rd_data = {r_req, 19'b0, r_level, r_vec};
            default:      ;
        endcase
    end

    // Registered read data, updated only by a read access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_data;
        end
    end

    assign intr_req   = r_req;
    assign intr_level = r_level;
    assign intr_vec   = r_vec;
    assign reg_rdata  = r_rdata;

endmodule

// File: tb/tb_intc_responder.sv
// tb_intc_responder: scoreboard-based bench for intc_responder (NSRC=16, VEC_BASE=64).
// Expected words go into a queue when stimulus is applied and are popped when the
// DUT's output is due. Inputs change and outputs are sampled on the falling edge.
module tb_intc_responder;

`ifdef INTC_IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] irq = '0;
    logic        intr_req;
    logic [3:0]  intr_level;
    logic [7:0]  intr_vec;
    logic        inta_ack = 1'b0;
    logic        reg_sel = 1'b0;
    logic        reg_wr = 1'b0;
    logic [7:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;

    intc_responder #(.NSRC(16), .VEC_BASE(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .intr_req   (intr_req),
        .intr_level (intr_level),
        .intr_vec   (intr_vec),
        .inta_ack   (inta_ack),
        .reg_sel    (reg_sel),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got 0x%08h with no expected entry queued", got);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    function automatic logic [31:0] cur_word();
        return {intr_req, 19'b0, intr_level, intr_vec};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare the presented request against the expected {req, level, vec} word.
    task automatic exp_intr(input string tag, input logic req, input logic [3:0] lvl,
                            input logic [7:0] vec);
        sb_push(tag, {req, 19'b0, lvl, vec});
        sb_pop(cur_word());
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
        reg_sel   = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick(1);
        reg_sel   = 1'b0;
        reg_wr    = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        reg_sel  = 1'b1;
        reg_wr   = 1'b0;
        reg_addr = addr;
        sb_push(tag, exp);
        tick(1);
        reg_sel  = 1'b0;
        sb_pop(reg_rdata);
    endtask

    task automatic pulse(input logic [15:0] mask);
        irq = irq | mask;
        tick(1);
        irq = irq & ~mask;
    endtask

    task automatic ack();
        inta_ack = 1'b1;
        tick(1);
        inta_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(2);
        exp_intr("rst_outputs", 1'b0, 4'd0, 8'd0);
        check("rst_rdata", reg_rdata, 32'h0);
        rst_n = 1'b1;
        tick(1);
        reg_read(8'h88, 32'h0, "rst_cur");
        reg_read(8'h84, 32'h0, "rst_pending");
        reg_read(8'h80, 32'h0, "rst_enable");

        // Test 1: single edge source, latency, ack
        reg_write(8'h0C, 32'h105);
        reg_write(8'h80, 32'h8);
        pulse(16'h0008);
        tick(LAT - 1);
        exp_intr("t1_early", 1'b0, 4'd0, 8'd0);
        tick(1);
        exp_intr("t1_req", 1'b1, 4'd5, 8'd67);
        reg_read(8'h84, 32'h8, "t1_pending");
        reg_read(8'h88, 32'h8000_0543, "t1_cur");
        ack();
        exp_intr("t1_ack_drop", 1'b0, 4'd0, 8'd0);
        reg_read(8'h84, 32'h0, "t1_pending_clr");
        exp_intr("t1_stays_off", 1'b0, 4'd0, 8'd0);

        // Test 2: priority order, and tie broken by lowest index
        reg_write(8'h08, 32'h107);
        reg_write(8'h14, 32'h107);
        reg_write(8'h24, 32'h10C);
        reg_write(8'h80, 32'h224);
        pulse(16'h0224);
        tick(LAT);
        exp_intr("t2_first", 1'b1, 4'd12, 8'd73);
        ack();
        exp_intr("t2_gap1", 1'b0, 4'd0, 8'd0);
        tick(1);
        exp_intr("t2_second", 1'b1, 4'd7, 8'd66);
        ack();
        exp_intr("t2_gap2", 1'b0, 4'd0, 8'd0);
        tick(1);
        exp_intr("t2_third", 1'b1, 4'd7, 8'd69);
        ack();
        tick(1);
        exp_intr("t2_empty", 1'b0, 4'd0, 8'd0);

        // Test 3: level source held high
        reg_write(8'h04, 32'h003);
        reg_write(8'h80, 32'h2);
        irq[1] = 1'b1;
        tick(LAT + 1);
        exp_intr("t3_req", 1'b1, 4'd3, 8'd65);
        ack();
        exp_intr("t3_gap", 1'b0, 4'd0, 8'd0);
        tick(1);
        exp_intr("t3_reassert", 1'b1, 4'd3, 8'd65);
        reg_write(8'h84, 32'h2);
        reg_read(8'h84, 32'h2, "t3_w1c_ignored");
        exp_intr("t3_still_req", 1'b1, 4'd3, 8'd65);
        irq[1] = 1'b0;
        tick(LAT);
        exp_intr("t3_not_yet_low", 1'b1, 4'd3, 8'd65);
        tick(1);
        exp_intr("t3_dropped", 1'b0, 4'd0, 8'd0);

        // Test 4: a new edge lands in the same cycle as W1C and ack, so set wins
        reg_write(8'h10, 32'h102);
        reg_write(8'h80, 32'h10);
        pulse(16'h0010);
        tick(LAT);
        exp_intr("t4_req", 1'b1, 4'd2, 8'd68);
        irq[4] = 1'b1;
        tick(LAT - 1);
        inta_ack  = 1'b1;
        reg_sel   = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = 8'h84;
        reg_wdata = 32'h10;
        tick(1);
        inta_ack  = 1'b0;
        reg_sel   = 1'b0;
        reg_wr    = 1'b0;
        exp_intr("t4_ack_drop", 1'b0, 4'd0, 8'd0);
        reg_read(8'h84, 32'h10, "t4_pending_kept");
        exp_intr("t4_represent", 1'b1, 4'd2, 8'd68);
        irq[4] = 1'b0;
        tick(LAT + 1);
        reg_write(8'h84, 32'h10);
        reg_read(8'h84, 32'h0, "t4_w1c_clear");
        exp_intr("t4_idle", 1'b0, 4'd0, 8'd0);

        // Test 5: level 0 and a disabled source never request; unmapped access
        reg_write(8'h00, 32'h100);
        reg_write(8'h80, 32'h1);
        pulse(16'h0001);
        tick(LAT);
        exp_intr("t5_lvl0_quiet", 1'b0, 4'd0, 8'd0);
        reg_read(8'h84, 32'h1, "t5_pending_lvl0");
        reg_write(8'h00, 32'h101);
        exp_intr("t5_not_yet", 1'b0, 4'd0, 8'd0);
        tick(1);
        exp_intr("t5_lvl1_req", 1'b1, 4'd1, 8'd64);
        reg_read(8'h00, 32'h101, "t5_prio_rd");
        reg_write(8'h80, 32'h0);
        exp_intr("t5_dis_pre", 1'b1, 4'd1, 8'd64);
        tick(1);
        exp_intr("t5_disabled", 1'b0, 4'd0, 8'd0);
        reg_write(8'h80, 32'hFFFF_0001);
        tick(1);
        exp_intr("t5_reenabled", 1'b1, 4'd1, 8'd64);
        reg_read(8'h80, 32'h0000_0001, "t5_enable_hi_bits");
        reg_write(8'h40, 32'h10F);
        reg_read(8'h40, 32'h0, "t5_unmapped");

        // Test 6: asynchronous reset while a request is presented
        exp_intr("t6_before", 1'b1, 4'd1, 8'd64);
        #2;
        rst_n = 1'b0;
        #1;
        exp_intr("t6_async_out", 1'b0, 4'd0, 8'd0);
        check("t6_async_rdata", reg_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        reg_read(8'h00, 32'h0, "t6_prio0");
        reg_read(8'h80, 32'h0, "t6_enable");
        reg_read(8'h84, 32'h0, "t6_pending");
        reg_read(8'h88, 32'h0, "t6_cur");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
